data_bus_interconnect: RTL and testbench
========================================

// Module: data_bus_interconnect
// PURPOSE
//   Parametrised successor to the fixed CPU<->RAM data-bus wiring: connects the single CPU data-bus
//   master to SLAVE_CNT memory-mapped slaves (RAM, GPIO, UART, timer ...). Adds a req/ready handshake
//   toward the master, address decoding with lowest-index priority, per-slave req/ack handshakes,
//   an unmapped-address error response and a bus timeout. One transaction is outstanding at a time.
// PARAMETERS
//   SLAVE_CNT   4                    number of slave ports, 1..16
//   ADDR_W      32                   address width
//   DATA_W      32                   data width, multiple of 8; MASK_W = DATA_W/8
//   SLAVE_BASE  {SLAVE_CNT*ADDR_W}   flat vector, slave i base at [i*ADDR_W +: ADDR_W]
//   SLAVE_MASK  {SLAVE_CNT*ADDR_W}   flat vector, slave i hits when (addr & MASK_i) == BASE_i
//   TIMEOUT     255                  cycles in WAIT without ack before error, 1..65535
// PORTS
//   sysClk     in   1               single clock, rising edge
//   sysRes     in   1               asynchronous, active-low reset
//   m_req      in   1               master request; held high until m_ready
//   m_we       in   1               1 = write, 0 = read
//   m_addr     in   ADDR_W          byte address
//   m_wdata    in   DATA_W          write data
//   m_mask     in   MASK_W          byte-lane write mask
//   m_ready    out  1               one-cycle completion pulse
//   m_rdata    out  DATA_W          read data, valid while m_ready
//   m_err      out  1               error flag (unmapped or timeout), valid while m_ready
//   s_req      out  SLAVE_CNT       one-hot request to selected slave
//   s_we       out  1               broadcast, registered copy of m_we
//   s_addr     out  ADDR_W          broadcast, registered copy of m_addr
//   s_wdata    out  DATA_W          broadcast, registered copy of m_wdata
//   s_mask     out  MASK_W          broadcast, registered copy of m_mask
//   s_ack      in   SLAVE_CNT       per-slave completion
//   s_rdata    in   SLAVE_CNT*DATA_W  per-slave read data, slave i at [i*DATA_W +: DATA_W]
// BEHAVIOUR
//   Reset (sysRes=0, any time, incl. mid-transaction): state IDLE; s_req=0, m_ready=0, m_err=0,
//     m_rdata=0, s_we=0, s_addr=0, s_wdata=0, s_mask=0, timeout counter=0. In-flight access dropped.
//   FSM states IDLE, WAIT, RESP. All outputs registered.
//   IDLE: m_req=1 -> latch we/addr/wdata/mask into s_* regs, decode. Hit on slave i (lowest i wins
//     on overlap) -> latch index, s_req[i]=1 next cycle, go WAIT. No hit -> go RESP with err=1.
//   WAIT: s_req[sel] held; counter increments each cycle. s_ack[sel]=1 -> s_req=0, capture
//     s_rdata[sel] (writes capture 0), go RESP err=0. Counter reaches TIMEOUT with no ack ->
//     s_req=0, rdata=0, go RESP err=1. Ack and timeout in same cycle: ack wins.
//   RESP: m_ready=1 for exactly one cycle with m_rdata/m_err; next state IDLE; m_rdata/m_err
//     return to 0 the following cycle.
//   Latency: m_req accepted cycle 0, s_req high from cycle 1; ack in cycle k>=1 -> m_ready cycle k+1.
//     Min 2 cycles; unmapped -> m_ready+m_err in cycle 1. Max throughput 1 access / 3 cycles.
//   m_req and master inputs ignored outside IDLE; s_ack from non-selected slaves or outside WAIT
//     ignored. s_* broadcast data stable for the whole WAIT phase.
//   Counter width = clog2(TIMEOUT+1); cleared on entry to WAIT; no wrap possible.
// STRUCTURE
//   constants.vh: FSM state encodings, default memory map (RAM/peripheral base+mask) macros.
//   Sub-module addr_decoder (combinational): addr -> hit flag + binary index, lowest-index priority.
//   Top-level integration: cpu data bus drives m_*, ram port 2 becomes slave 0.
// TESTING
//   Read slave 0 (BASE 0x0, MASK 0xFFFF0000), addr 0x10, ack after 3 cycles, rdata 0xDEADBEEF ->
//     m_ready in cycle 4, m_rdata=0xDEADBEEF, m_err=0, s_req[0] high cycles 1-3 only.
//   Write addr 0x0001_0004 to slave 1, wdata 0x12345678 mask 4'b0011, ack in cycle 1 ->
//     s_addr/s_wdata/s_mask match, m_ready cycle 2, m_rdata=0, m_err=0.
//   Unmapped addr 0xF000_0000 -> no s_req ever, m_ready=1 m_err=1 m_rdata=0 in cycle 1.
//   TIMEOUT=8, slave never acks -> s_req high cycles 1-8, m_ready+m_err in cycle 9.
//   Overlapping slaves 0 and 2 both hit -> only s_req[0]; spurious s_ack[2] ignored.
//   sysRes low during WAIT -> s_req/m_ready immediately 0, next m_req serviced normally.

Source files
------------

// File: rtl/data_bus_interconnect_pkg.sv
// Shared types and default memory map for the CPU data-bus interconnect.
package data_bus_interconnect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } busState_t;

  // Default map: RAM at 0x0000_xxxx, then three 64 KiB peripheral windows
  localparam int DEF_SLAVE_CNT = 4;
  localparam logic [DEF_SLAVE_CNT*32-1:0] DEF_SLAVE_BASE =
    {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [DEF_SLAVE_CNT*32-1:0] DEF_SLAVE_MASK = {DEF_SLAVE_CNT{32'hFFFF_0000}};

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_bus_interconnect_addr_decoder.sv
// Combinational address decoder: hit flag plus binary index, lowest slave index wins on overlap.
module data_bus_interconnect_addr_decoder
  import data_bus_interconnect_pkg::*;
#(
  parameter int SLAVE_CNT = 4,
  parameter int ADDR_W    = 32,
  parameter int IDX_W     = idxWidth(SLAVE_CNT),
  parameter logic [SLAVE_CNT*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [SLAVE_CNT*ADDR_W-1:0] SLAVE_MASK = '0
)(
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  logic [SLAVE_CNT-1:0] slvHit;

  for (genvar i = 0; i < SLAVE_CNT; i++) begin : g_cmp
    assign slvHit[i] = (addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W];
  end

  // Scan downwards so the lowest matching index is the one left standing
  always_comb begin
    hit = |slvHit;
    idx = '0;
    for (int i = SLAVE_CNT - 1; i >= 0; i--) begin
      if (slvHit[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/data_bus_interconnect.sv
// Single-master, SLAVE_CNT-slave data bus with req/ready toward the CPU, req/ack toward slaves,
// unmapped-address error and per-access timeout. One access in flight; all outputs registered.
module data_bus_interconnect
  import data_bus_interconnect_pkg::*;
#(
  parameter int SLAVE_CNT = DEF_SLAVE_CNT,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter logic [SLAVE_CNT*ADDR_W-1:0] SLAVE_BASE = (SLAVE_CNT*ADDR_W)'(DEF_SLAVE_BASE),
  parameter logic [SLAVE_CNT*ADDR_W-1:0] SLAVE_MASK = (SLAVE_CNT*ADDR_W)'(DEF_SLAVE_MASK),
  parameter int TIMEOUT   = 255,
  localparam int MASK_W   = DATA_W / 8
)(
  input  logic                        sysClk,
  input  logic                        sysRes,
  input  logic                        m_req,
  input  logic                        m_we,
  input  logic [ADDR_W-1:0]           m_addr,
  input  logic [DATA_W-1:0]           m_wdata,
  input  logic [MASK_W-1:0]           m_mask,
  output logic                        m_ready,
  output logic [DATA_W-1:0]           m_rdata,
  output logic                        m_err,
  output logic [SLAVE_CNT-1:0]        s_req,
  output logic                        s_we,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [DATA_W-1:0]           s_wdata,
  output logic [MASK_W-1:0]           s_mask,
  input  logic [SLAVE_CNT-1:0]        s_ack,
  input  logic [SLAVE_CNT*DATA_W-1:0] s_rdata
);

  localparam int IDX_W = idxWidth(SLAVE_CNT);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  busState_t state, stateNxt;
  logic                              hit;
  logic [IDX_W-1:0]                  decIdx, sel;
  logic [CNT_W-1:0]                  cnt;
  logic [SLAVE_CNT-1:0][DATA_W-1:0]  slvRdata;
  logic                              selAck, tmo, accept;
  logic [SLAVE_CNT-1:0]              sReqNxt;
  logic                              readyNxt, errNxt;
  logic [DATA_W-1:0]                 rdataNxt;

  data_bus_interconnect_addr_decoder #(
    .SLAVE_CNT (SLAVE_CNT),
    .ADDR_W    (ADDR_W),
    .IDX_W     (IDX_W),
    .SLAVE_BASE(SLAVE_BASE),
    .SLAVE_MASK(SLAVE_MASK)
  ) uDec (
    .addr(m_addr),
    .hit (hit),
    .idx (decIdx)
  );

  assign slvRdata = s_rdata;
  assign selAck   = s_ack[sel];
  assign tmo      = (cnt == CNT_W'(TIMEOUT - 1));
  assign accept   = (state == ST_IDLE) && m_req;

  always_comb begin
    stateNxt = state;
    unique case (state)
      ST_IDLE: if (m_req) stateNxt = hit ? ST_WAIT : ST_RESP;
      ST_WAIT: if (selAck || tmo) stateNxt = ST_RESP;
      ST_RESP: stateNxt = ST_IDLE;
      default: stateNxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; ack takes precedence over timeout
  always_comb begin
    sReqNxt  = '0;
    readyNxt = 1'b0;
    errNxt   = 1'b0;
    rdataNxt = '0;
    unique case (state)
      ST_IDLE: if (m_req) begin
        if (hit) sReqNxt = SLAVE_CNT'(1) << decIdx;
        else begin
          readyNxt = 1'b1;
          errNxt   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (selAck) begin
          readyNxt = 1'b1;
          rdataNxt = s_we ? '0 : slvRdata[sel];
        end else if (tmo) begin
          readyNxt = 1'b1;
          errNxt   = 1'b1;
        end else begin
          sReqNxt = s_req;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysClk or negedge sysRes) begin
    if (!sysRes) begin
      state   <= ST_IDLE;
      s_req   <= '0;
      m_ready <= 1'b0;
      m_err   <= 1'b0;
      m_rdata <= '0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_mask  <= '0;
      sel     <= '0;
      cnt     <= '0;
    end else begin
      state   <= stateNxt;
      s_req   <= sReqNxt;
      m_ready <= readyNxt;
      m_err   <= errNxt;
      m_rdata <= rdataNxt;
      if (accept) begin
        s_we    <= m_we;
        s_addr  <= m_addr;
        s_wdata <= m_wdata;
        s_mask  <= m_mask;
        sel     <= decIdx;
      end
      // Zero everywhere but WAIT, so it is clear on WAIT entry and peaks at TIMEOUT
      cnt <= (state == ST_WAIT) ? cnt + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_data_bus_interconnect.sv
// Randomised bench for data_bus_interconnect against a transaction-level model of the bus timing.
module tb_data_bus_interconnect;
  localparam int SC = 4, AW = 32, DW = 32, MW = DW / 8, TO = 8;
  // slave 2 overlaps the low 4 KiB of slave 0; slave 3 covers 0x2xxxx and 0x3xxxx
  localparam logic [SC*AW-1:0] BASE = {32'h0002_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [SC*AW-1:0] MASK = {32'hFFFE_0000, 32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000};

  logic sysClk = 1'b0, sysRes = 1'b1;
  logic m_req, m_we, m_ready, m_err, s_we;
  logic [AW-1:0] m_addr, s_addr;
  logic [DW-1:0] m_wdata, m_rdata, s_wdata;
  logic [MW-1:0] m_mask, s_mask;
  logic [SC-1:0] s_req, s_ack;
  logic [SC*DW-1:0] s_rdata;

  int nChk = 0, nPass = 0;
  bit chkEn = 0;
  logic eReady, eErr, eSwe;
  logic [DW-1:0] eRdata, eSwdata;
  logic [SC-1:0] eSreq;
  logic [AW-1:0] eSaddr;
  logic [MW-1:0] eSmask;

  int rCyc, sCnt;
  logic [SC-1:0] sOr;
  logic [DW-1:0] rData;
  logic rErr;

  always #5 sysClk = ~sysClk;

  data_bus_interconnect #(
    .SLAVE_CNT(SC), .ADDR_W(AW), .DATA_W(DW),
    .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT(TO)
  ) dut (
    .sysClk(sysClk), .sysRes(sysRes),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_mask(m_mask),
    .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_mask(s_mask),
    .s_ack(s_ack), .s_rdata(s_rdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int decode(input logic [AW-1:0] a);
    for (int i = 0; i < SC; i++)
      if ((a & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) return i;
    return -1;
  endfunction

  task automatic zeroExp(input bit all);
    eReady = 0; eErr = 0; eRdata = '0; eSreq = '0;
    if (all) begin eSwe = 0; eSaddr = '0; eSwdata = '0; eSmask = '0; end
  endtask

  task automatic randSlaves();
    s_ack = SC'($urandom);
    for (int i = 0; i < SC; i++) s_rdata[i*DW +: DW] = $urandom;
  endtask

  always @(negedge sysClk) if (chkEn) begin
    check("m_ready", 64'(m_ready), 64'(eReady));
    check("m_err",   64'(m_err),   64'(eErr));
    check("m_rdata", 64'(m_rdata), 64'(eRdata));
    check("s_req",   64'(s_req),   64'(eSreq));
    check("s_we",    64'(s_we),    64'(eSwe));
    check("s_addr",  64'(s_addr),  64'(eSaddr));
    check("s_wdata", 64'(s_wdata), 64'(eSwdata));
    check("s_mask",  64'(s_mask),  64'(eSmask));
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sysClk); #1;
      m_req = 0; m_we = 1'($urandom); m_addr = $urandom; m_wdata = $urandom; m_mask = MW'($urandom);
      randSlaves();
      zeroExp(0);
    end
  endtask

  // One master access starting in an IDLE cycle (cycle 0). ackAt: cycle the target slave acks
  // (0 = never). rstAt: cycle at which reset is pulsed (-1 = none).
  task automatic run(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                     input logic [MW-1:0] mk, input int ackAt, input logic [DW-1:0] rdv, input int rstAt);
    int idx, endC, rdyAt;
    bit acked;
    idx = decode(addr);
    if (idx < 0) begin endC = 0; acked = 0; end
    else if (ackAt >= 1 && ackAt <= TO) begin endC = ackAt; acked = 1; end
    else begin endC = TO; acked = 0; end
    rdyAt = endC + 1;
    rCyc = -1; sCnt = 0; sOr = '0; rData = '0; rErr = 0;
    for (int c = 0; c <= rdyAt; c++) begin
      @(posedge sysClk); #1;
      m_req = 1;
      if (c == 0) begin m_we = we; m_addr = addr; m_wdata = wd; m_mask = mk; end
      else begin m_we = 1'($urandom); m_addr = $urandom; m_wdata = $urandom; m_mask = MW'($urandom); end
      randSlaves();
      if (idx >= 0 && c >= 1 && c <= endC) begin
        s_ack[idx] = (c == ackAt);
        if (c == ackAt) s_rdata[idx*DW +: DW] = rdv;
      end
      if (c == 1) begin eSwe = we; eSaddr = addr; eSwdata = wd; eSmask = mk; end
      eSreq  = (idx >= 0 && c >= 1 && c <= endC) ? (SC'(1) << idx) : '0;
      eReady = (c == rdyAt);
      eErr   = (c == rdyAt) && !acked;
      eRdata = (c == rdyAt && acked && !we) ? rdv : '0;
      if (c == rstAt) begin
        #1 sysRes = 0; m_req = 0; zeroExp(1);
        #1;
        check("rst s_req", 64'(s_req), 64'(0));
        check("rst m_ready", 64'(m_ready), 64'(0));
        check("rst s_addr", 64'(s_addr), 64'(0));
        @(negedge sysClk); #1 sysRes = 1;
        return;
      end
      @(negedge sysClk);
      if (m_ready && rCyc < 0) begin rCyc = c; rData = m_rdata; rErr = m_err; end
      if (s_req != '0) sCnt++;
      sOr |= s_req;
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    int r;
    m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_mask = '0; s_ack = '0; s_rdata = '0;
    zeroExp(1);
    #2 sysRes = 0;
    chkEn = 1;
    repeat (2) @(posedge sysClk);
    @(negedge sysClk); #1 sysRes = 1;

    run(0, 32'h0000_0010, '0, '0, 3, 32'hDEADBEEF, -1);
    check("rd ready cycle", 64'(rCyc), 64'(4));
    check("rd rdata", 64'(rData), 64'h0000_0000_DEAD_BEEF);
    check("rd err", 64'(rErr), 64'(0));
    check("rd s_req cycles", 64'(sCnt), 64'(3));

    run(1, 32'h0001_0004, 32'h1234_5678, 4'b0011, 1, 32'hCAFE_F00D, -1);
    check("wr ready cycle", 64'(rCyc), 64'(2));
    check("wr rdata", 64'(rData), 64'(0));
    check("wr err", 64'(rErr), 64'(0));
    check("wr s_addr", 64'(s_addr), 64'h0001_0004);
    check("wr s_wdata", 64'(s_wdata), 64'h1234_5678);
    check("wr s_mask", 64'(s_mask), 64'h3);
    check("wr s_req slave", 64'(sOr), 64'h2);

    idle(1);
    run(0, 32'hF000_0000, '0, '0, 1, 32'h1111_1111, -1);
    check("unmapped ready cycle", 64'(rCyc), 64'(1));
    check("unmapped err", 64'(rErr), 64'(1));
    check("unmapped rdata", 64'(rData), 64'(0));
    check("unmapped s_req", 64'(sCnt), 64'(0));

    run(0, 32'h0001_0000, '0, '0, 0, 32'h2222_2222, -1);
    check("timeout ready cycle", 64'(rCyc), 64'(9));
    check("timeout err", 64'(rErr), 64'(1));
    check("timeout s_req cycles", 64'(sCnt), 64'(8));
    check("timeout rdata", 64'(rData), 64'(0));

    run(0, 32'h0000_0800, '0, '0, 5, 32'hA5A5_5A5A, -1);
    check("overlap s_req", 64'(sOr), 64'h1);
    check("overlap rdata", 64'(rData), 64'h0000_0000_A5A5_5A5A);
    check("overlap ready cycle", 64'(rCyc), 64'(6));

    run(0, 32'h0001_0040, '0, '0, TO, 32'h7777_0001, -1);
    check("ack at limit cycle", 64'(rCyc), 64'(9));
    check("ack at limit err", 64'(rErr), 64'(0));

    run(0, 32'h0001_0020, '0, '0, 6, 32'h3333_3333, 3);
    idle(1);
    run(0, 32'h0003_0040, '0, '0, 2, 32'h0BAD_F00D, -1);
    check("post-reset ready cycle", 64'(rCyc), 64'(3));
    check("post-reset rdata", 64'(rData), 64'h0000_0000_0BAD_F00D);
    check("post-reset s_req", 64'(sOr), 64'h8);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: a = {16'h0000, 16'($urandom)};
        1: a = {16'h0001, 16'($urandom)};
        2: a = {15'h0001, 17'($urandom)};
        3: a = $urandom;
        default: a = {16'h0004, 16'($urandom)};
      endcase
      run(1'($urandom), a, $urandom, MW'($urandom), $urandom_range(0, 10), $urandom, -1);
      idle($urandom_range(0, 2));
    end

    chkEn = 0;
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
